mem_wb_stage: RTL and testbench

- Memory stage plus MEM/WB pipeline register of the pipelined RV32I core; directly downstream of the EX/MEM register, consumes its M-stage outputs.
- Drives the data-memory bus with a req/ack handshake and stalls the pipeline while an access is outstanding.
- Aligns, sign- or zero-extends load data, selects the writeback result and registers the W-stage signals for the register file.

---
 rtl/mem_wb_stage_if.sv | 12 +
 rtl/mem_wb_stage.sv | 108 ++++++++++
 tb/tb_mem_wb_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: data-memory req/ack bus between the memory stage and data memory
interface mem_wb_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport master(output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: RV32I memory stage and MEM/WB register; MEM_TIMEOUT_EN adds a bus wait timeout
module mem_wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic                  MemReadM,
  input  logic [2:0]            Funct3M,
  mem_wb_stage_if.master        bus,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic [4:0]            RdW,
  output logic                  RegWriteW,
  output logic                  MisalignW,
  output logic                  BusErrW
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_result;
  logic [4:0]            r_rd;
  logic                  r_rw, r_mis;
  logic                  w_mem, w_legal, w_aligned, w_acc, w_bad, w_to;
  logic [15:0]           w_lane;
  logic [DATA_WIDTH-1:0] w_load, w_result;
  assign w_mem     = MemReadM | MemWriteM;
  assign w_legal   = MemWriteM ? (Funct3M inside {3'b000, 3'b001, 3'b010})
                               : (Funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign w_aligned = (Funct3M[1:0] == 2'b00) | ((Funct3M[1:0] == 2'b01) & ~ALUResultM[0]) |
                     ((Funct3M[1:0] == 2'b10) & (ALUResultM[1:0] == 2'b00));
  assign w_acc     = w_mem & w_aligned & w_legal;
  assign w_bad     = w_mem & ~(w_aligned & w_legal);
`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] r_cnt;
  logic          r_buserr;
  assign w_to    = (r_state == WAIT) && (r_cnt == CW'(TIMEOUT_CYCLES));
  assign BusErrW = r_buserr;
  // wait-cycle counter: held at zero in IDLE so it starts clean on every IDLE->WAIT
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else     r_cnt <= (r_state == IDLE) ? '0 : r_cnt + 1'b1;
  // bus error pulse registered on the edge that ends an abandoned access
  always_ff @(posedge clk or posedge rst)
    if (rst) r_buserr <= 1'b0;
    else     r_buserr <= w_to;
`else
  assign w_to    = 1'b0;
  assign BusErrW = 1'b0;
`endif
  // access FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // next state and handshake; a timed-out access drops its request and releases the stall
  always_comb begin
    w_next      = r_state;
    bus.mem_req = 1'b0;
    w_next      = (r_state == IDLE) ? ((w_acc & ~bus.mem_ack) ? WAIT : IDLE)
                                    : ((bus.mem_ack | w_to) ? IDLE : WAIT);
    bus.mem_req = ~rst & ((r_state == IDLE) ? w_acc : ~w_to);
  end
  assign stall_o       = bus.mem_req & ~bus.mem_ack;
  assign bus.mem_we    = MemWriteM;
  assign bus.mem_addr  = {ALUResultM[31:2], 2'b00};
  assign bus.mem_be    = ~MemWriteM                ? 4'b1111 :
                         (Funct3M[1:0] == 2'b00)   ? 4'b0001 << ALUResultM[1:0] :
                         (Funct3M[1:0] == 2'b01)   ? 4'b0011 << {ALUResultM[1], 1'b0} : 4'b1111;
  assign bus.mem_wdata = (Funct3M[1:0] == 2'b00) ? {4{WriteDataM[7:0]}} :
                         (Funct3M[1:0] == 2'b01) ? {2{WriteDataM[15:0]}} : WriteDataM;
  assign w_lane   = 16'(bus.mem_rdata >> {ALUResultM[1:0], 3'b000});
  assign w_load   = (Funct3M == 3'b000) ? {{24{w_lane[7]}}, w_lane[7:0]} :
                    (Funct3M == 3'b001) ? {{16{w_lane[15]}}, w_lane} :
                    (Funct3M == 3'b100) ? {24'b0, w_lane[7:0]} :
                    (Funct3M == 3'b101) ? {16'b0, w_lane} : bus.mem_rdata;
  assign w_result = (ResultSrcM == 2'b01) ? w_load : (ResultSrcM == 2'b10) ? PCPlus4M : ALUResultM;
  // W register: bubble while stalled or aborted, flag misaligned/illegal accesses, else retire
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_result <= '0;
      r_rd     <= '0;
      r_rw     <= 1'b0;
      r_mis    <= 1'b0;
    end else if (stall_o | w_to) begin
      r_rw     <= 1'b0;
      r_mis    <= 1'b0;
    end else if (w_bad) begin
      r_rw     <= 1'b0;
      r_mis    <= 1'b1;
      r_rd     <= RdM;
    end else begin
      r_rw     <= RegWriteM;
      r_rd     <= RdM;
      r_result <= w_result;
      r_mis    <= 1'b0;
    end
  assign ResultW   = r_result;
  assign RdW       = r_rd;
  assign RegWriteW = r_rw;
  assign MisalignW = r_mis;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scoreboard bench for mem_wb_stage (timeout steps under MEM_TIMEOUT_EN)
module tb_mem_wb_stage;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM, MemReadM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic        stall_o;
  logic [31:0] ResultW;
  logic [4:0]  RdW;
  logic        RegWriteW, MisalignW, BusErrW;
  mem_wb_stage_if bus();
  mem_wb_stage #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
    .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .MemReadM(MemReadM), .Funct3M(Funct3M), .bus(bus), .stall_o(stall_o), .ResultW(ResultW),
    .RdW(RdW), .RegWriteW(RegWriteW), .MisalignW(MisalignW), .BusErrW(BusErrW)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } exp_t;
  exp_t        q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] last_res = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic drive(input logic rd_, input logic wr_, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input logic rw, input logic [1:0] src);
    MemReadM = rd_;
    MemWriteM = wr_;
    Funct3M = f3;
    ALUResultM = a;
    WriteDataM = wd;
    RdM = rd;
    RegWriteM = rw;
    ResultSrcM = src;
    PCPlus4M = 32'h0000_1000;
  endtask
  task automatic expect_w(input logic [31:0] res, input logic [4:0] rd, input logic rw, input logic mis);
    q.push_back('{res: mis ? last_res : res, rd: rd, rw: rw, mis: mis});
    if (!mis) last_res = res;
  endtask
  task automatic retire(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, " ResultW"}, ResultW, e.res);
    chk({tag, " RdW"}, 32'(RdW), 32'(e.rd));
    chk({tag, " RegWriteW"}, 32'(RegWriteW), 32'(e.rw));
    chk({tag, " MisalignW"}, 32'(MisalignW), 32'(e.mis));
    chk({tag, " BusErrW"}, 32'(BusErrW), 32'd0);
  endtask
  task automatic bus_op(input string tag, input logic [31:0] rdata, input int delay);
    bus.mem_rdata = rdata;
    bus.mem_ack = (delay == 0);
    #1;
    chk({tag, " req"}, 32'(bus.mem_req), 32'd1);
    chk({tag, " stall_first"}, 32'(stall_o), 32'(delay != 0));
    for (int i = 0; i < delay; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " bubble"}, 32'(RegWriteW), 32'd0);
      chk({tag, " req_wait"}, 32'(bus.mem_req), 32'd1);
      if (i == delay - 1) bus.mem_ack = 1'b1;
      #1;
      chk({tag, " stall_wait"}, 32'(stall_o), 32'(i != delay - 1));
    end
    retire(tag);
    bus.mem_ack = 1'b0;
  endtask
  task automatic no_req(input string tag);
    #1;
    chk({tag, " no_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, " no_stall"}, 32'(stall_o), 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    drive(1, 0, 3'b010, 32'h100, 0, 5'd5, 1, 2'b01);
    no_req("reset");
    chk("reset ResultW", ResultW, 32'd0);
    chk("reset RdW", 32'(RdW), 32'd0);
    chk("reset RegWriteW", 32'(RegWriteW), 32'd0);
    chk("reset MisalignW", 32'(MisalignW), 32'd0);
    chk("reset BusErrW", 32'(BusErrW), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 0, 3'b010, 32'h100, 0, 5'd5, 1, 2'b01);
    expect_w(32'hDEAD_BEEF, 5'd5, 1, 0);
    bus_op("lw", 32'hDEAD_BEEF, 0);
    drive(1, 0, 3'b000, 32'h103, 0, 5'd6, 1, 2'b01);
    expect_w(32'hFFFF_FF80, 5'd6, 1, 0);
    bus_op("lb", 32'h8011_2233, 3);
    drive(1, 0, 3'b100, 32'h103, 0, 5'd7, 1, 2'b01);
    expect_w(32'h0000_0080, 5'd7, 1, 0);
    bus_op("lbu", 32'h8011_2233, 3);
    drive(1, 0, 3'b001, 32'h102, 0, 5'd8, 1, 2'b01);
    expect_w(32'hFFFF_8011, 5'd8, 1, 0);
    bus_op("lh", 32'h8011_2233, 1);
    drive(1, 0, 3'b101, 32'h100, 0, 5'd9, 1, 2'b01);
    expect_w(32'h0000_F00D, 5'd9, 1, 0);
    bus_op("lhu", 32'h1234_F00D, 0);
    drive(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 5'd10, 0, 2'b00);
    #1;
    chk("sh be", 32'(bus.mem_be), 32'b1100);
    chk("sh wdata", bus.mem_wdata, 32'hABCD_ABCD);
    chk("sh we", 32'(bus.mem_we), 32'd1);
    chk("sh addr", bus.mem_addr, 32'h200);
    expect_w(32'h202, 5'd10, 0, 0);
    bus_op("sh", 32'h0, 0);
    drive(0, 1, 3'b000, 32'h301, 32'h1234_565A, 5'd11, 0, 2'b00);
    #1;
    chk("sb be", 32'(bus.mem_be), 32'b0010);
    chk("sb wdata", bus.mem_wdata, 32'h5A5A_5A5A);
    expect_w(32'h301, 5'd11, 0, 0);
    bus_op("sb", 32'h0, 2);
    drive(0, 1, 3'b010, 32'h304, 32'hCAFE_F00D, 5'd12, 0, 2'b00);
    #1;
    chk("sw be", 32'(bus.mem_be), 32'b1111);
    chk("sw wdata", bus.mem_wdata, 32'hCAFE_F00D);
    chk("sw addr", bus.mem_addr, 32'h304);
    expect_w(32'h304, 5'd12, 0, 0);
    bus_op("sw", 32'h0, 0);
    bus.mem_ack = 1'b1;
    drive(1, 0, 3'b010, 32'h101, 0, 5'd13, 1, 2'b01);
    no_req("lw_mis");
    expect_w(32'h0, 5'd13, 0, 1);
    retire("lw_mis");
    drive(1, 0, 3'b011, 32'h100, 0, 5'd14, 1, 2'b01);
    no_req("ld_f3_011");
    expect_w(32'h0, 5'd14, 0, 1);
    retire("ld_f3_011");
    drive(0, 1, 3'b100, 32'h100, 0, 5'd15, 0, 2'b00);
    no_req("st_f3_100");
    expect_w(32'h0, 5'd15, 0, 1);
    retire("st_f3_100");
    drive(0, 0, 3'b010, 32'h55, 0, 5'd16, 1, 2'b00);
    no_req("alu_ack_ignored");
    expect_w(32'h55, 5'd16, 1, 0);
    retire("alu_ack_ignored");
    bus.mem_ack = 1'b0;
    drive(0, 0, 3'b000, 32'h66, 0, 5'd1, 1, 2'b10);
    no_req("pc4");
    expect_w(32'h1000, 5'd1, 1, 0);
    retire("pc4");
    drive(0, 0, 3'b000, 32'h77, 0, 5'd2, 1, 2'b11);
    no_req("alu11");
    expect_w(32'h77, 5'd2, 1, 0);
    retire("alu11");
    drive(1, 0, 3'b010, 32'h400, 0, 5'd17, 1, 2'b01);
    #1;
    chk("rstwait stall_idle", 32'(stall_o), 32'd1);
    @(posedge clk);
    #1;
    chk("rstwait stall_wait", 32'(stall_o), 32'd1);
    rst = 1'b1;
    no_req("rstwait");
    chk("rstwait ResultW", ResultW, 32'd0);
    chk("rstwait RdW", 32'(RdW), 32'd0);
    chk("rstwait RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rstwait MisalignW", 32'(MisalignW), 32'd0);
    last_res = '0;
    drive(0, 0, 3'b000, 32'h42, 0, 5'd18, 1, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    no_req("post_rst_alu");
    expect_w(32'h42, 5'd18, 1, 0);
    retire("post_rst_alu");
`ifdef MEM_TIMEOUT_EN
    drive(1, 0, 3'b010, 32'h500, 0, 5'd19, 1, 2'b01);
    bus.mem_ack = 1'b0;
    #1;
    chk("to req_idle", 32'(bus.mem_req), 32'd1);
    for (int i = 0; i < TO; i++) begin
      @(posedge clk);
      #1;
      chk("to req_wait", 32'(bus.mem_req), 32'd1);
      chk("to stall_wait", 32'(stall_o), 32'd1);
    end
    @(posedge clk);
    #1;
    chk("to req_drop", 32'(bus.mem_req), 32'd0);
    chk("to stall_drop", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    chk("to BusErrW", 32'(BusErrW), 32'd1);
    chk("to RegWriteW", 32'(RegWriteW), 32'd0);
    drive(0, 0, 3'b000, 32'h7, 0, 5'd3, 1, 2'b00);
    expect_w(32'h7, 5'd3, 1, 0);
    retire("to after");
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
